// File: rtl/tf530_bus_master.sv
// 68000 asynchronous bus initiator for 030-side requests: sequences AS/UDS/LDS/RW,
// synchronises DTACK/BERR, splits longword requests into two word cycles, times out dead cycles.
module tf530_bus_master #(
    parameter int SETUP_CLKS = 2,
    parameter int HOLD_CLKS  = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [23:0] REQ_A,
    input  logic [1:0]  REQ_SIZ,
    input  logic [31:0] REQ_WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        BUSY,
    output logic [22:0] A00,
    output logic        RW00,
    output logic        AS00,
    output logic        UDS,
    output logic        LDS,
    output logic [15:0] D00_OUT,
    output logic        D00_OE,
    input  logic [15:0] D00_IN,
    input  logic        DTACK,
    input  logic        BERR
);

    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CLKS - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CLKS - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_RECOVER, S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        rw_reg, rw_next;
    logic [23:0] addr_reg, addr_next;
    logic [1:0]  siz_reg, siz_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        half_reg, half_next;
    logic        err_reg, err_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        dtack_s1_reg, dtack_s2_reg;
    logic        berr_s1_reg, berr_s2_reg;

    logic        misaligned;
    logic        in_bus;
    logic        strobing;
    logic        ds_on;
    logic        uds_lane;
    logic        lds_lane;
    logic [7:0]  byte_sel;

    assign misaligned = (REQ_SIZ == 2'b11)
                     || (REQ_SIZ == SIZ_WORD && REQ_A[0])
                     || (REQ_SIZ == SIZ_LONG && REQ_A[1:0] != 2'b00);

    assign byte_sel = addr_reg[0] ? D00_IN[7:0] : D00_IN[15:8];

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_reg <= S_IDLE;
            rw_reg    <= 1'b1;
            addr_reg  <= '0;
            siz_reg   <= '0;
            wdata_reg <= '0;
            half_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            siz_reg   <= siz_next;
            wdata_reg <= wdata_next;
            half_reg  <= half_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
        end
    end

    // Synchronisers are held negated while AS00 is high so a stale DTACK
    // from the previous cycle can never terminate the next one.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            dtack_s1_reg <= 1'b1;
            dtack_s2_reg <= 1'b1;
            berr_s1_reg  <= 1'b1;
            berr_s2_reg  <= 1'b1;
        end else if (!strobing) begin
            dtack_s1_reg <= 1'b1;
            dtack_s2_reg <= 1'b1;
            berr_s1_reg  <= 1'b1;
            berr_s2_reg  <= 1'b1;
        end else begin
            dtack_s1_reg <= DTACK;
            dtack_s2_reg <= dtack_s1_reg;
            berr_s1_reg  <= BERR;
            berr_s2_reg  <= berr_s1_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        siz_next   = siz_reg;
        wdata_next = wdata_reg;
        half_next  = half_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (REQ) begin
                    rw_next    = REQ_RW;
                    addr_next  = REQ_A;
                    siz_next   = REQ_SIZ;
                    wdata_next = REQ_WDATA;
                    half_next  = 1'b0;
                    err_next   = misaligned;
                    cnt_next   = '0;
                    rdata_next = '0;
                    state_next = misaligned ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    cnt_next   = '0;
                    state_next = S_STROBE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_STROBE: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!berr_s2_reg || (dtack_s2_reg && cnt_reg == WAIT_LAST)) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = S_RECOVER;
                end else if (!dtack_s2_reg) begin
                    if (rw_reg) begin
                        case (siz_reg)
                            SIZ_BYTE: rdata_next = {4{byte_sel}};
                            SIZ_LONG: rdata_next = half_reg ? {rdata_reg[31:16], D00_IN}
                                                            : {D00_IN, rdata_reg[15:0]};
                            default:  rdata_next = {2{D00_IN}};
                        endcase
                    end
                    cnt_next   = '0;
                    state_next = S_RECOVER;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next = '0;
                    if (!err_reg && siz_reg == SIZ_LONG && !half_reg) begin
                        half_next  = 1'b1;
                        state_next = S_SETUP;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign in_bus   = (state_reg == S_SETUP) || (state_reg == S_STROBE)
                   || (state_reg == S_WAIT)  || (state_reg == S_RECOVER);
    assign strobing = (state_reg == S_STROBE) || (state_reg == S_WAIT);
    // Reads drive data strobes with AS; writes wait one clock so data is settled first.
    assign ds_on    = (state_reg == S_WAIT) || (state_reg == S_STROBE && rw_reg);
    assign uds_lane = (siz_reg != SIZ_BYTE) || !addr_reg[0];
    assign lds_lane = (siz_reg != SIZ_BYTE) ||  addr_reg[0];

    assign AS00    = !strobing;
    assign UDS     = !(ds_on && uds_lane);
    assign LDS     = !(ds_on && lds_lane);
    assign RW00    = in_bus ? rw_reg : 1'b1;
    assign A00     = {addr_reg[23:2], addr_reg[1] | half_reg};
    assign D00_OUT = (siz_reg == SIZ_BYTE) ? {2{wdata_reg[31:24]}}
                   : (half_reg ? wdata_reg[15:0] : wdata_reg[31:16]);
    assign D00_OE  = in_bus && !rw_reg;
    assign ACK     = (state_reg == S_DONE);
    assign ERR     = (state_reg == S_DONE) && err_reg;
    assign BUSY    = in_bus;
    assign RDATA   = rdata_reg;

endmodule

// File: tb/tb_tf530_bus_master.sv
// Directed bench for tf530_bus_master: table of single requests plus timeout,
// BERR and mid-cycle reset sequences against a simple motherboard slave.
module tb_tf530_bus_master;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic        REQ;
    logic        REQ_RW;
    logic [23:0] REQ_A;
    logic [1:0]  REQ_SIZ;
    logic [31:0] REQ_WDATA;
    logic        ACK, ERR, BUSY;
    logic [31:0] RDATA;
    logic [22:0] A00;
    logic        RW00, AS00, UDS, LDS, D00_OE;
    logic [15:0] D00_OUT;
    logic [15:0] D00_IN;
    logic        DTACK, BERR;

    tf530_bus_master dut (
        .CLKCPU(CLKCPU), .RESET(RESET), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_A(REQ_A),
        .REQ_SIZ(REQ_SIZ), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
        .BUSY(BUSY), .A00(A00), .RW00(RW00), .AS00(AS00), .UDS(UDS), .LDS(LDS),
        .D00_OUT(D00_OUT), .D00_OE(D00_OE), .D00_IN(D00_IN), .DTACK(DTACK), .BERR(BERR)
    );

    always #5 CLKCPU = ~CLKCPU;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Slave model controls (written only by the main process)
    int          dtack_dly = 3;
    bit          no_dtack  = 0;
    int          berr_at   = 0;
    logic [15:0] rd0 = 16'h0, rd1 = 16'h0;

    // Per bus-cycle log (written only by the slave process)
    int          ncyc = 0;
    int          as_cnt = 0;
    int          high_cnt = 0;
    logic [5:0]  idx = '0;
    logic [22:0] cyc_a     [64];
    logic        cyc_rw    [64];
    logic        cyc_oe    [64];
    logic [15:0] cyc_dout  [64];
    logic [1:0]  cyc_lanes [64];
    int          cyc_len   [64];
    int          cyc_gap   [64];

    initial begin
        DTACK = 1'b1;
        BERR = 1'b1;
        D00_IN = '0;
        forever begin
            @(posedge CLKCPU);
            #1;
            if (!AS00) begin
                if (as_cnt == 0) begin
                    idx = ncyc[5:0];
                    cyc_a[idx] = A00;
                    cyc_rw[idx] = RW00;
                    cyc_oe[idx] = D00_OE;
                    cyc_dout[idx] = D00_OUT;
                    cyc_gap[idx] = high_cnt;
                    cyc_lanes[idx] = 2'b00;
                end
                cyc_lanes[idx] = cyc_lanes[idx] | {!UDS, !LDS};
                as_cnt++;
                if (berr_at != 0 && as_cnt >= berr_at) BERR = 1'b0;
                if (!no_dtack && as_cnt >= dtack_dly) begin
                    DTACK = 1'b0;
                    D00_IN = A00[0] ? rd1 : rd0;
                end
            end else begin
                if (as_cnt != 0) begin
                    cyc_len[idx] = as_cnt;
                    ncyc++;
                    high_cnt = 0;
                end
                as_cnt = 0;
                high_cnt++;
                DTACK = 1'b1;
                BERR = 1'b1;
            end
        end
    end

    // Strobe invariant monitor
    int          inv_bad = 0;
    logic [22:0] prev_a  = '0;
    logic        prev_rw = 1'b1;
    initial begin
        forever begin
            @(negedge CLKCPU);
            if (!AS00 && (A00 !== prev_a || RW00 !== prev_rw)) inv_bad++;
            if (AS00 && (!UDS || !LDS)) inv_bad++;
            prev_a = A00;
            prev_rw = RW00;
        end
    end

    typedef struct {
        logic        rw;
        logic [23:0] a;
        logic [1:0]  siz;
        logic [31:0] wdata;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        err;
        logic [31:0] rdata;
        int          ncyc;
        logic [22:0] a0;
        logic [22:0] a1;
        logic [1:0]  lanes;
        logic [15:0] dout0;
        logic [15:0] dout1;
    } vec_t;

    vec_t vecs[10];

    // Results of the last request
    bit          r_ok;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_lat;
    int          r_base;
    logic        r_busy1;
    logic        r_ack_after;
    logic        r_busy_ack;

    task automatic do_req(input logic rw, input logic [23:0] a, input logic [1:0] siz,
                          input logic [31:0] wd);
        r_base = ncyc;
        @(negedge CLKCPU);
        REQ = 1'b1; REQ_RW = rw; REQ_A = a; REQ_SIZ = siz; REQ_WDATA = wd;
        @(negedge CLKCPU);
        REQ = 1'b0;
        r_busy1 = BUSY;
        r_ok = 0;
        r_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            if (ACK) begin
                r_ok = 1;
                break;
            end
            @(negedge CLKCPU);
            r_lat++;
        end
        r_err = ERR;
        r_rdata = RDATA;
        r_busy_ack = BUSY;
        @(negedge CLKCPU);
        r_ack_after = ACK;
        $display("TXN rw=%0d a=%06h siz=%0d wdata=%08h ack=%0d err=%0d rdata=%08h cycles=%0d lat=%0d",
                 rw, a, siz, wd, r_ok, r_err, r_rdata, ncyc - r_base, r_lat);
    endtask

    initial begin
        vecs[0] = '{1'b1, 24'hDA1001, 2'b01, 32'h0, 16'h12AB, 16'h12AB, 1'b0, 32'hABABABAB, 1,
                    23'h6D0800, 23'h0, 2'b01, 16'h0, 16'h0};
        vecs[1] = '{1'b1, 24'h000010, 2'b01, 32'h0, 16'h12AB, 16'h12AB, 1'b0, 32'h12121212, 1,
                    23'h000008, 23'h0, 2'b10, 16'h0, 16'h0};
        vecs[2] = '{1'b1, 24'h400002, 2'b10, 32'h0, 16'hCAFE, 16'hCAFE, 1'b0, 32'hCAFECAFE, 1,
                    23'h200001, 23'h0, 2'b11, 16'h0, 16'h0};
        vecs[3] = '{1'b1, 24'hC00000, 2'b00, 32'h0, 16'h1234, 16'h5678, 1'b0, 32'h12345678, 2,
                    23'h600000, 23'h600001, 2'b11, 16'h0, 16'h0};
        vecs[4] = '{1'b0, 24'h200000, 2'b00, 32'hDEADBEEF, 16'h0, 16'h0, 1'b0, 32'h0, 2,
                    23'h100000, 23'h100001, 2'b11, 16'hDEAD, 16'hBEEF};
        vecs[5] = '{1'b0, 24'h000101, 2'b01, 32'h5A000000, 16'h0, 16'h0, 1'b0, 32'h0, 1,
                    23'h000080, 23'h0, 2'b01, 16'h5A5A, 16'h0};
        vecs[6] = '{1'b0, 24'h000200, 2'b10, 32'h13579BDF, 16'h0, 16'h0, 1'b0, 32'h0, 1,
                    23'h000100, 23'h0, 2'b11, 16'h1357, 16'h0};
        vecs[7] = '{1'b1, 24'h000003, 2'b10, 32'h0, 16'h0, 16'h0, 1'b1, 32'h0, 0,
                    23'h0, 23'h0, 2'b00, 16'h0, 16'h0};
        vecs[8] = '{1'b0, 24'h000002, 2'b00, 32'h11223344, 16'h0, 16'h0, 1'b1, 32'h0, 0,
                    23'h0, 23'h0, 2'b00, 16'h0, 16'h0};
        vecs[9] = '{1'b1, 24'h000000, 2'b11, 32'h0, 16'h0, 16'h0, 1'b1, 32'h0, 0,
                    23'h0, 23'h0, 2'b00, 16'h0, 16'h0};

        RESET = 1'b0;
        REQ = 1'b0; REQ_RW = 1'b1; REQ_A = '0; REQ_SIZ = 2'b01; REQ_WDATA = '0;
        repeat (3) @(negedge CLKCPU);
        chk("reset_strobes", {AS00, UDS, LDS, RW00}, 4'b1111);
        chk("reset_oe_ack_err_busy", {D00_OE, ACK, ERR, BUSY}, 4'b0000);
        chk("reset_a00", A00, 23'h0);
        chk("reset_dout", D00_OUT, 16'h0);
        chk("reset_rdata", RDATA, 32'h0);
        RESET = 1'b1;
        @(negedge CLKCPU);

        for (int v = 0; v < 10; v++) begin
            rd0 = vecs[v].d0;
            rd1 = vecs[v].d1;
            do_req(vecs[v].rw, vecs[v].a, vecs[v].siz, vecs[v].wdata);
            chk($sformatf("v%0d_ack", v), r_ok, 1'b1);
            chk($sformatf("v%0d_err", v), r_err, vecs[v].err);
            chk($sformatf("v%0d_ncyc", v), ncyc - r_base, vecs[v].ncyc);
            chk($sformatf("v%0d_ack_pulse", v), r_ack_after, 1'b0);
            chk($sformatf("v%0d_busy_at_ack", v), r_busy_ack, 1'b0);
            if (vecs[v].rw && !vecs[v].err)
                chk($sformatf("v%0d_rdata", v), r_rdata, vecs[v].rdata);
            if (vecs[v].ncyc == 0) begin
                chk($sformatf("v%0d_mis_latency_le3", v), r_lat <= 3, 1'b1);
            end else begin
                chk($sformatf("v%0d_busy", v), r_busy1, 1'b1);
                for (int c = 0; c < vecs[v].ncyc; c++) begin
                    idx = 6'(r_base + c);
                    chk($sformatf("v%0d_c%0d_a00", v, c), cyc_a[idx],
                        (c == 0) ? vecs[v].a0 : vecs[v].a1);
                    chk($sformatf("v%0d_c%0d_rw", v, c), cyc_rw[idx], vecs[v].rw);
                    chk($sformatf("v%0d_c%0d_oe", v, c), cyc_oe[idx], !vecs[v].rw);
                    chk($sformatf("v%0d_c%0d_lanes", v, c), cyc_lanes[idx], vecs[v].lanes);
                    if (!vecs[v].rw)
                        chk($sformatf("v%0d_c%0d_dout", v, c), cyc_dout[idx],
                            (c == 0) ? vecs[v].dout0 : vecs[v].dout1);
                    if (c == 1)
                        chk($sformatf("v%0d_gap_ge_hold", v), cyc_gap[idx] >= 1, 1'b1);
                end
            end
        end

        // Dead cycle: AS low for STROBE plus 255 WAIT clocks, then error
        no_dtack = 1;
        do_req(1'b1, 24'h000004, 2'b01, 32'h0);
        idx = 6'(r_base);
        chk("tmo_ack", r_ok, 1'b1);
        chk("tmo_err", r_err, 1'b1);
        chk("tmo_ncyc", ncyc - r_base, 1);
        chk("tmo_as_len", cyc_len[idx], 256);

        // BERR on the first half of a longword read: no second word
        berr_at = 4;
        do_req(1'b1, 24'h800000, 2'b00, 32'h0);
        chk("berr_ack", r_ok, 1'b1);
        chk("berr_err", r_err, 1'b1);
        chk("berr_ncyc", ncyc - r_base, 1);
        chk("berr_rdata", r_rdata, 32'h0);
        berr_at = 0;

        // Reset in the middle of WAIT on a word write
        begin
            bit seen_as;
            bit ack_in_reset;
            seen_as = 0;
            ack_in_reset = 0;
            @(negedge CLKCPU);
            REQ = 1'b1; REQ_RW = 1'b0; REQ_A = 24'h000400; REQ_SIZ = 2'b10; REQ_WDATA = 32'hA5A5_0000;
            @(negedge CLKCPU);
            REQ = 1'b0;
            for (int i = 0; i < 50; i++) begin
                if (!AS00) begin
                    seen_as = 1;
                    break;
                end
                @(negedge CLKCPU);
            end
            chk("rst_as_seen", seen_as, 1'b1);
            repeat (3) @(negedge CLKCPU);
            chk("rst_pre_strobes", {AS00, UDS, LDS, D00_OE}, 4'b0001);
            #2;
            RESET = 1'b0;
            #1;
            chk("rst_async_strobes", {AS00, UDS, LDS, D00_OE}, 4'b1110);
            for (int i = 0; i < 3; i++) begin
                @(negedge CLKCPU);
                if (ACK) ack_in_reset = 1;
            end
            chk("rst_no_ack", ack_in_reset, 1'b0);
            RESET = 1'b1;
            @(negedge CLKCPU);
            if (ACK) ack_in_reset = 1;
            chk("rst_no_ack_after_release", ack_in_reset, 1'b0);
        end

        no_dtack = 0;
        rd0 = 16'h12AB;
        rd1 = 16'h12AB;
        do_req(1'b1, 24'hDA1001, 2'b01, 32'h0);
        chk("post_rst_ack", r_ok, 1'b1);
        chk("post_rst_err", r_err, 1'b0);
        chk("post_rst_rdata", r_rdata, 32'hABABABAB);
        chk("post_rst_ncyc", ncyc - r_base, 1);

        chk("strobe_invariant", inv_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
